// File: rtl/fetch_program_counter.sv
// Fetch-stage program counter: loads PC_In when PC_En is high, holds otherwise,
// and returns to RESET_VECTOR on synchronous active-low RST. Optional macro: PC_MISALIGN_FLAG_EN.
module fetch_program_counter #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            PC_En,
    input  logic [XLEN-1:0] PC_In,
`ifdef PC_MISALIGN_FLAG_EN
    output logic            PC_Misaligned,
`endif
    output logic [XLEN-1:0] PC_Out
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // Stall selects the held value, so PC_In (even if X) never reaches the flop.
    always_comb begin
        pc_d = pc_q;
        if (PC_En) begin
            pc_d = PC_In;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC_Out = pc_q;

`ifdef PC_MISALIGN_FLAG_EN
    logic misaligned_d;
    logic misaligned_q;

    // Flag follows the value being loaded so it lines up with PC_Out.
    always_comb begin
        misaligned_d = misaligned_q;
        if (PC_En) begin
            misaligned_d = |PC_In[1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign PC_Misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_fetch_program_counter.sv
// Self-checking bench for fetch_program_counter: vector table, hand-written
// corner sequences and randomized load/stall/reset runs against a reference model.
module tb_fetch_program_counter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PC_En;
    logic [31:0] PC_In;
    logic [31:0] out_a;
    logic [31:0] out_b;
`ifdef PC_MISALIGN_FLAG_EN
    logic        mis_a;
    logic        mis_b;
`endif

    always #5 CLK = ~CLK;

    fetch_program_counter #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut_a (
        .CLK          (CLK),
        .RST          (RST),
        .PC_En        (PC_En),
        .PC_In        (PC_In),
`ifdef PC_MISALIGN_FLAG_EN
        .PC_Misaligned(mis_a),
`endif
        .PC_Out       (out_a)
    );

    fetch_program_counter #(.XLEN(32), .RESET_VECTOR(32'h0000_1000)) dut_b (
        .CLK          (CLK),
        .RST          (RST),
        .PC_En        (PC_En),
        .PC_In        (PC_In),
`ifdef PC_MISALIGN_FLAG_EN
        .PC_Misaligned(mis_b),
`endif
        .PC_Out       (out_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the PC each instance should hold.
    logic [31:0] model_a;
    logic [31:0] model_b;

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check32({tag, " pc_a"}, out_a, model_a);
        check32({tag, " pc_b"}, out_b, model_b);
`ifdef PC_MISALIGN_FLAG_EN
        check1({tag, " mis_a"}, mis_a, model_a[1:0] != 2'b00);
        check1({tag, " mis_b"}, mis_b, model_b[1:0] != 2'b00);
`endif
    endtask

    // Drive one cycle's inputs, take the edge, update the model, settle.
    task automatic apply(input logic r, input logic e, input logic [31:0] d);
        RST   = r;
        PC_En = e;
        PC_In = d;
        @(posedge CLK);
        if (!r) begin
            model_a = 32'h0000_0000;
            model_b = 32'h0000_1000;
        end else if (e) begin
            model_a = d;
            model_b = d;
        end
        #1;
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_ABCD, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_0004};
        vecs[6] = '{1'b0, 1'b1, 32'h1234_5678, 32'h0000_0000};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_0102, 32'h0000_0102};
        vecs[8] = '{1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[9] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_0004};

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].din);
            $display("vec %0d: rst=%b en=%b in=%h -> pc_a=%h pc_b=%h", i,
                     vecs[i].rst, vecs[i].en, vecs[i].din, out_a, out_b);
            check32($sformatf("vec%0d pc_a", i), out_a, vecs[i].exp);
            check_model($sformatf("vec%0d", i));
        end

        // Reset vector parameter: reset then load a word-aligned PC.
        apply(1'b0, 1'b0, 32'h0000_0000);
        check32("rv1000 reset", out_b, 32'h0000_1000);
        apply(1'b1, 1'b1, 32'h0000_0004);
        check32("rv1000 load", out_b, 32'h0000_0004);
`ifdef PC_MISALIGN_FLAG_EN
        check1("rv1000 mis", mis_b, 1'b0);
`endif
        $display("seq rv: pc_b=%h", out_b);

        // Long stall with an undriven PC_In must hold the last loaded value.
        apply(1'b1, 1'b1, 32'h0000_0081);
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b0, 32'hxxxx_xxxx);
            check32($sformatf("xstall%0d", i), out_a, 32'h0000_0081);
            check_model($sformatf("xstall%0d", i));
        end
        apply(1'b1, 1'b1, 32'h0000_0200);
        check32("xstall resume", out_a, 32'h0000_0200);
        $display("seq xstall: pc_a=%h", out_a);

        // Randomized segments: loads, stalls, occasional mid-run reset.
        for (int seg = 0; seg < 25; seg++) begin
            int n_load;
            int n_stall;
            n_load  = $urandom_range(10, 3);
            n_stall = $urandom_range(10, 3);
            for (int k = 0; k < n_load; k++) begin
                apply(1'b1, 1'b1, $urandom);
                check_model($sformatf("rnd%0d load%0d", seg, k));
            end
            for (int k = 0; k < n_stall; k++) begin
                apply(1'b1, 1'b0, $urandom);
                check_model($sformatf("rnd%0d stall%0d", seg, k));
            end
            apply(1'b1, 1'b1, $urandom);
            check_model($sformatf("rnd%0d resume", seg));
            if ($urandom_range(3, 0) == 0) begin
                apply(1'b0, 1'b1, 32'h1234_5678);
                check32($sformatf("rnd%0d reset", seg), out_a, 32'h0000_0000);
                check_model($sformatf("rnd%0d reset", seg));
            end
            $display("seg %0d: loads=%0d stalls=%0d pc_a=%h", seg, n_load, n_stall, out_a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
